// File: rtl/servant_wb_arbiter.sv
// rtl/servant_wb_arbiter.sv - round-robin N-master to 1-slave Wishbone arbiter (optional SERVANT_ARB_TIMEOUT_EN watchdog)
module servant_wb_arbiter #(
  parameter int NM      = 3,
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [NM*AW-1:0] i_m_adr,
  input  logic [NM*32-1:0] i_m_dat,
  input  logic [NM*4-1:0]  i_m_sel,
  input  logic [NM-1:0]    i_m_we,
  input  logic [NM-1:0]    i_m_cyc,
  output logic [31:0]      o_m_rdt,
  output logic [NM-1:0]    o_m_ack,
  output logic [AW-1:0]    o_s_adr,
  output logic [31:0]      o_s_dat,
  output logic [3:0]       o_s_sel,
  output logic             o_s_we,
  output logic             o_s_cyc,
  input  logic [31:0]      i_s_rdt,
  input  logic             i_s_ack,
  output logic [NM-1:0]    o_grant,
  output logic             o_timeout
);

  localparam int IW = $clog2(NM);

  // Reject illegal parameterisations at elaboration
  if (NM < 2 || NM > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_err
    $error("servant_wb_arbiter: NM or TIMEOUT out of range");
  end

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e        state_q, state_d;
  logic [NM-1:0] grant_q, grant_d;
  logic [IW-1:0] gidx_q, gidx_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] ptr_next;
  logic          busy;
  logic          cyc_g;
  logic          to_hit;

  assign busy     = (state_q == S_BUSY);
  assign cyc_g    = i_m_cyc[gidx_q];
  assign ptr_next = (gidx_q == IW'(NM - 1)) ? '0 : gidx_q + IW'(1);

`ifdef SERVANT_ARB_TIMEOUT_EN
  logic [15:0] cnt_q;
  logic        timeout_q;

  // A slave ack in the same cycle wins over the watchdog
  assign to_hit    = busy & cyc_g & ~i_s_ack & (cnt_q == 16'(TIMEOUT));
  assign o_timeout = timeout_q;

  // Wait counter: zero while idle so every grant starts from zero; sticky flag
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= (busy && !i_s_ack) ? cnt_q + 16'd1 : '0;
      timeout_q <= timeout_q | to_hit;
    end
  end
`else
  assign to_hit    = 1'b0;
  assign o_timeout = 1'b0;
`endif

  // Arbiter state, owner and round-robin pointer registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next state: pick first requester from the pointer upward; release on ack, abort or watchdog
  always_comb begin
    logic [IW:0]   sum;
    logic [IW-1:0] cand;
    logic          found;
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    sum     = '0;
    cand    = '0;
    found   = 1'b0;
    case (state_q)
      S_IDLE: begin
        for (int i = 0; i < NM; i++) begin
          sum = {1'b0, ptr_q} + (IW + 1)'(i);
          if (sum >= (IW + 1)'(NM)) sum = sum - (IW + 1)'(NM);
          cand = sum[IW-1:0];
          if (!found && i_m_cyc[cand]) begin
            found   = 1'b1;
            gidx_d  = cand;
            grant_d = NM'(1) << cand;
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (i_s_ack || !cyc_g || to_hit) begin
          state_d = S_IDLE;
          grant_d = '0;
          ptr_d   = ptr_next;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Slave side follows the owner while busy and is quiet while idle
  always_comb begin
    o_s_adr = '0;
    o_s_dat = '0;
    o_s_sel = '0;
    o_s_we  = 1'b0;
    o_s_cyc = 1'b0;
    if (busy) begin
      o_s_adr = i_m_adr[gidx_q*AW +: AW];
      o_s_dat = i_m_dat[gidx_q*32 +: 32];
      o_s_sel = i_m_sel[gidx_q*4 +: 4];
      o_s_we  = i_m_we[gidx_q];
      o_s_cyc = cyc_g & ~to_hit;
    end
  end

  assign o_grant = grant_q;
  assign o_m_ack = (busy && (i_s_ack || to_hit)) ? grant_q : '0;
  assign o_m_rdt = to_hit ? 32'd0 : i_s_rdt;

endmodule

// File: doc/servant_wb_arbiter.md
SERVANT_WB_ARBITER -- requirements
Module: servant_wb_arbiter

Interface
REQ-001 SHALL have parameter NM, default 3: number of Wishbone masters, legal range 2..8.
REQ-002 SHALL have parameter AW, default 32: address width.
REQ-003 SHALL have parameter TIMEOUT, default 255: slave-wait cycles before forced termination, legal range 1..65535.
REQ-004 SHALL have port i_clk, input, 1: system clock, all logic on rising edge.
REQ-005 SHALL have port i_rst, input, 1: synchronous active-high reset.
REQ-006 SHALL have port i_m_adr, input, NM*AW: master addresses, master k at [k*AW +: AW].
REQ-007 SHALL have port i_m_dat, input, NM*32: master write data.
REQ-008 SHALL have port i_m_sel, input, NM*4: master byte selects.
REQ-009 SHALL have port i_m_we, input, NM: master write enables.
REQ-010 SHALL have port i_m_cyc, input, NM: master cycle requests.
REQ-011 SHALL have port o_m_rdt, output, 32: read data, broadcast to all masters.
REQ-012 SHALL have port o_m_ack, output, NM: per-master acknowledge.
REQ-013 SHALL have ports o_s_adr (output, AW), o_s_dat (output, 32), o_s_sel (output, 4), o_s_we (output, 1), o_s_cyc (output, 1): slave request.
REQ-014 SHALL have ports i_s_rdt (input, 32) and i_s_ack (input, 1): slave response.
REQ-015 SHALL have port o_grant, output, NM: one-hot current owner, all zero when idle.
REQ-016 SHALL have port o_timeout, output, 1: sticky flag, set when any transfer was force-terminated.

Function
REQ-017 SHALL implement a two-state FSM: IDLE and BUSY.
REQ-018 In IDLE with any i_m_cyc high, SHALL register a grant to the first requesting master at or after pointer P, searching upward modulo NM, and enter BUSY.
REQ-019 SHALL assert o_s_cyc exactly one cycle after the granting request cycle; latency from cyc to slave cyc is 1 clock.
REQ-020 In BUSY, o_s_adr/dat/sel/we SHALL combinationally follow the granted master; o_s_cyc SHALL be the granted master's i_m_cyc.
REQ-021 In IDLE, o_s_cyc and o_s_we SHALL be 0; other o_s_* outputs SHALL be 0.
REQ-022 o_m_ack[g] SHALL equal i_s_ack while BUSY with grant g; all other o_m_ack bits SHALL be 0, and all bits SHALL be 0 in IDLE.
REQ-023 o_m_rdt SHALL equal i_s_rdt combinationally.
REQ-024 On i_s_ack in BUSY, SHALL return to IDLE and set P = (g+1) mod NM; at least one IDLE cycle SHALL separate consecutive grants.
REQ-025 If the granted master drops i_m_cyc before ack (abort), SHALL return to IDLE next cycle with no ack issued; P SHALL still advance to (g+1) mod NM.
REQ-026 A new request arriving in the same cycle as i_s_ack SHALL be considered in the following IDLE cycle, not in the current one.
REQ-027 A master whose request is not granted SHALL be served within NM grants (no starvation).
REQ-028 i_s_ack received in IDLE SHALL be ignored.

Reset
REQ-029 On i_rst: state IDLE, P=0, o_grant=0, o_s_cyc=0, o_m_ack=0, o_timeout=0, timeout counter=0; reset mid-BUSY SHALL abandon the transfer without ack.

Configuration
REQ-030 With macro SERVANT_ARB_TIMEOUT_EN defined, SHALL count BUSY cycles without i_s_ack; when the count reaches TIMEOUT, SHALL pulse o_m_ack[g] for one cycle with o_m_rdt forced to 0, deassert o_s_cyc, set o_timeout, and return to IDLE with P advanced.
REQ-031 The counter SHALL clear on entry to BUSY; an i_s_ack arriving in the same cycle the count reaches TIMEOUT SHALL take precedence as a normal ack, leaving o_timeout unchanged.
REQ-032 Without SERVANT_ARB_TIMEOUT_EN, SHALL include no counter, SHALL tie o_timeout to 0, and SHALL wait indefinitely for i_s_ack.

Verification
REQ-033 Single master: NM=3, m1 reads 0x100, slave acks 2 cycles after o_s_cyc with 0xDEADBEEF -> o_grant=3'b010, o_m_ack[1] pulses once, o_m_rdt=0xDEADBEEF.
REQ-034 Round robin: all three masters hold cyc, each acked after 1 cycle -> grant order m0, m1, m2, m0, each grant separated by exactly one IDLE cycle.
REQ-035 Abort: m2 granted, drops cyc before ack -> no o_m_ack, IDLE next cycle, next grant goes to m0 when m0 and m2 both request.
REQ-036 Timeout (macro on, TIMEOUT=4): slave never acks -> o_m_ack[g] pulses 4 cycles after o_s_cyc rises, rdt=0, o_timeout=1 and stays 1.
REQ-037 Timeout/ack race (macro on, TIMEOUT=4): i_s_ack on the 4th cycle -> normal ack with slave data, o_timeout stays 0.
REQ-038 Reset mid-BUSY: assert i_rst while m0 is granted -> next cycle o_grant=0, o_s_cyc=0, no ack, P=0.
